// File: rtl/tis_prog_loader.sv
// Program loader: parses a framed byte stream into per-core instruction and
// length tables, holding the cores in reset until the frame checksum is good.
module tis_prog_loader #(
  parameter int unsigned NUM_CORES = 12,
  parameter int unsigned MAX_INSTR = 15,
  parameter int unsigned INSTR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               prog_we,
  output logic [7:0]         prog_addr,
  output logic [INSTR_W-1:0] prog_wdata,
  output logic               len_we,
  output logic [3:0]         len_addr,
  output logic [3:0]         len_wdata,
  output logic               core_rst,
  output logic               done,
  output logic               error
);

  localparam int unsigned AW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned BW = 8;

  localparam logic [BW-1:0] SYNC      = 8'hA5;
  localparam logic [BW-1:0] MAX_LEN_B = BW'(MAX_INSTR);
  localparam logic [CW-1:0] MAX_LEN   = CW'(MAX_INSTR);
  localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_INSTR - 1);
  localparam logic [CW-1:0] LAST_CORE = CW'(NUM_CORES - 1);
  localparam logic [AW-1:0] STRIDE    = AW'(MAX_INSTR);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_PAD, S_CSUM, S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] len_q, len_d;
  logic [AW-1:0] base_q, base_d;
  logic [BW-1:0] hi_q, hi_d;
  logic [BW-1:0] csum_q, csum_d;

  logic               prog_we_d;
  logic [AW-1:0]      prog_addr_d;
  logic [INSTR_W-1:0] prog_wdata_d;
  logic               len_we_d;
  logic [CW-1:0]      len_addr_d;
  logic [CW-1:0]      len_wdata_d;
  logic               core_rst_d;
  logic               done_d;
  logic               error_d;

  logic          acc;
  logic          last_core;
  logic          last_word;
  logic [AW-1:0] slot_addr;

  assign acc       = in_valid & in_ready;
  assign last_core = (c_q == LAST_CORE);
  assign last_word = (i_q == len_q - CW'(1));
  assign slot_addr = base_q + AW'(i_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (acc && in_data == SYNC) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (acc) begin
          if (in_data > MAX_LEN_B)   state_nxt = S_IDLE;
          else if (in_data != 8'h00) state_nxt = S_HI;
          else                       state_nxt = S_PAD;
        end
      end
      S_HI: begin
        if (acc) state_nxt = S_LO;
      end
      S_LO: begin
        if (acc) begin
          if (!last_word)            state_nxt = S_HI;
          else if (len_q != MAX_LEN) state_nxt = S_PAD;
          else if (last_core)        state_nxt = S_CSUM;
          else                       state_nxt = S_LEN;
        end
      end
      S_PAD: begin
        if (i_q == LAST_SLOT) state_nxt = last_core ? S_CSUM : S_LEN;
      end
      S_CSUM: begin
        if (acc) state_nxt = (in_data == csum_q) ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and next values of the registered datapath/outputs
  always_comb begin
    in_ready     = (state != S_PAD);
    c_d          = c_q;
    i_d          = i_q;
    len_d        = len_q;
    base_d       = base_q;
    hi_d         = hi_q;
    csum_d       = csum_q;
    prog_we_d    = 1'b0;
    prog_addr_d  = prog_addr;
    prog_wdata_d = prog_wdata;
    len_we_d     = 1'b0;
    len_addr_d   = len_addr;
    len_wdata_d  = len_wdata;
    core_rst_d   = core_rst;
    done_d       = done;
    error_d      = error;
    case (state)
      S_IDLE, S_RUN: begin
        if (acc && in_data == SYNC) begin
          c_d        = '0;
          base_d     = '0;
          csum_d     = '0;
          error_d    = 1'b0;
          done_d     = 1'b0;
          core_rst_d = 1'b1;
        end
      end
      S_LEN: begin
        if (acc) begin
          csum_d = csum_q ^ in_data;
          if (in_data > MAX_LEN_B) begin
            error_d = 1'b1;
          end else begin
            len_we_d    = 1'b1;
            len_addr_d  = c_q;
            len_wdata_d = in_data[CW-1:0];
            len_d       = in_data[CW-1:0];
            i_d         = '0;
          end
        end
      end
      S_HI: begin
        if (acc) begin
          csum_d = csum_q ^ in_data;
          hi_d   = in_data;
        end
      end
      S_LO: begin
        if (acc) begin
          csum_d       = csum_q ^ in_data;
          prog_we_d    = 1'b1;
          prog_addr_d  = slot_addr;
          prog_wdata_d = INSTR_W'({hi_q, in_data});
          i_d          = i_q + CW'(1);
          // A full-length program skips padding, so advance the core here
          if (last_word && len_q == MAX_LEN && !last_core) begin
            c_d    = c_q + CW'(1);
            base_d = base_q + STRIDE;
          end
        end
      end
      S_PAD: begin
        prog_we_d    = 1'b1;
        prog_addr_d  = slot_addr;
        prog_wdata_d = '0;
        i_d          = i_q + CW'(1);
        if (i_q == LAST_SLOT && !last_core) begin
          c_d    = c_q + CW'(1);
          base_d = base_q + STRIDE;
        end
      end
      S_CSUM: begin
        if (acc) begin
          if (in_data == csum_q) begin
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q        <= '0;
      i_q        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      hi_q       <= '0;
      csum_q     <= '0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      len_we     <= 1'b0;
      len_addr   <= '0;
      len_wdata  <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      c_q        <= c_d;
      i_q        <= i_d;
      len_q      <= len_d;
      base_q     <= base_d;
      hi_q       <= hi_d;
      csum_q     <= csum_d;
      prog_we    <= prog_we_d;
      prog_addr  <= prog_addr_d;
      prog_wdata <= prog_wdata_d;
      len_we     <= len_we_d;
      len_addr   <= len_addr_d;
      len_wdata  <= len_wdata_d;
      core_rst   <= core_rst_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

endmodule
